// File: rtl/uart_rx_ctrl_if.sv
// Receive-side result bus of uart_rx_ctrl: assembled byte, strobes and busy flag.
// master = the receiver driving results, slave = the consumer.
interface uart_rx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_int;
    logic                 frame_err;
    logic                 parity_err;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_int,
        output frame_err,
        output parity_err
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input rx_int,
        input frame_err,
        input parity_err
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller, 8N1 (8E1 when UART_RX_PARITY_EN is defined), driven by
// mid-bit clk_bps pulses from an external baud generator armed through bps_start.
//
// state  | meaning
// IDLE   | waiting for a start-bit falling edge; clk_bps ignored
// START  | baud generator armed; mid-start sample decides real start vs glitch
// DATA   | shifting DATA_BITS samples in, LSB first
// PARITY | latching the even-parity sample (UART_RX_PARITY_EN only)
// STOP   | stop-bit sample; result strobed on the following cycle
module uart_rx_ctrl #(
    parameter int DATA_BITS = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rs232_rx,
    input  logic           clk_bps,
    output logic           bps_start,
    uart_rx_ctrl_if.master rx_bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t               state;
    state_t               state_nxt;
    logic                 sync1;
    logic                 sync2;
    logic                 sync3;
    logic                 fall;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] rx_data_q;
    logic [2:0]           bit_cnt;
    logic                 rx_valid_q;
    logic                 frame_err_q;
    logic                 shift_en;
    logic                 cnt_clr;
    logic                 load;
    logic                 ferr_set;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
    logic                 par_latch;
    logic                 par_ok;
    logic                 perr_set;
    logic                 parity_err_q;
`endif

    // Synchronizer flops reset to the idle line level so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= rs232_rx;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign fall = sync3 & ~sync2;

`ifdef UART_RX_PARITY_EN
    assign par_ok = ~(^shreg ^ par_bit);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        cnt_clr   = 1'b0;
        load      = 1'b0;
        ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_latch = 1'b0;
        perr_set  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (fall) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (clk_bps) begin
                    if (!sync2) begin
                        state_nxt = S_DATA;
                        cnt_clr   = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (clk_bps) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (clk_bps) begin
                    par_latch = 1'b1;
                    state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (clk_bps) begin
                    state_nxt = S_IDLE;
                    if (!sync2) begin
                        ferr_set = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (!par_ok) begin
                        perr_set = 1'b1;
`endif
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // New bits enter at the MSB so the first-received bit lands in bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= load;
            frame_err_q <= ferr_set;
            if (cnt_clr) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= {sync2, shreg[DATA_BITS-1:1]};
            end
            if (load) begin
                rx_data_q <= shreg;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit      <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= perr_set;
            if (par_latch) begin
                par_bit <= sync2;
            end
        end
    end

    assign rx_bus.parity_err = parity_err_q;
`else
    assign rx_bus.parity_err = 1'b0;
`endif

    assign bps_start        = (state != S_IDLE);
    assign rx_bus.rx_int    = (state != S_IDLE);
    assign rx_bus.rx_data   = rx_data_q;
    assign rx_bus.rx_valid  = rx_valid_q;
    assign rx_bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized + directed bench for uart_rx_ctrl with a behavioural baud generator and
// a frame-level expectation queue; honours UART_RX_PARITY_EN like the design.
module tb_uart_rx_ctrl;

    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_FERR  = 3'b010;
    localparam logic [2:0] K_PERR  = 3'b001;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS_AFTER_START = 10;
`else
    localparam int FRAME_BITS_AFTER_START = 9;
`endif

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    logic rs232_rx;
    logic clk_bps;
    logic bps_start;

    uart_rx_ctrl_if #(.DATA_BITS(8)) bus ();

    uart_rx_ctrl #(.DATA_BITS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs232_rx  (rs232_rx),
        .clk_bps   (clk_bps),
        .bps_start (bps_start),
        .rx_bus    (bus.master)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_valid  = 0;
    int   n_ferr   = 0;
    int   n_perr   = 0;
    int   bps_hi   = 0;
    int   bit_clks = 80;
    int   bps_cnt;
    logic [7:0] exp_data = 8'h00;
    exp_t q[$];

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Behavioural speed_setting: one-cycle pulse at mid-bit while armed.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bps_cnt <= 0;
            clk_bps <= 1'b0;
        end else if (!bps_start) begin
            bps_cnt <= 0;
            clk_bps <= 1'b0;
        end else begin
            bps_cnt <= (bps_cnt == bit_clks - 1) ? 0 : bps_cnt + 1;
            clk_bps <= (bps_cnt == bit_clks / 2);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [2:0] strobes;
        exp_t       e;
        strobes = {bus.rx_valid, bus.frame_err, bus.parity_err};
        if (!rst_n) begin
            exp_data = 8'h00;
            q.delete();
            check("reset_outputs", {19'd0, bps_start, bus.rx_int, strobes, bus.rx_data}, 32'd0);
        end else begin
            if (bps_start) bps_hi++;
            if (bus.rx_valid)   n_valid++;
            if (bus.frame_err)  n_ferr++;
            if (bus.parity_err) n_perr++;
            check("strobe_onehot", 32'($countones(strobes) <= 1), 32'd1);
            check("rx_int_vs_bps_start", 32'(bus.rx_int), 32'(bps_start));
            if (strobes != 3'b000) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got %b expected none at %0t", strobes, $time);
                end else begin
                    e = q.pop_front();
                    check("strobe_kind", 32'(strobes), 32'(e.kind));
                    if (e.kind == K_VALID) exp_data = e.data;
                end
            end
            check("rx_data_model", 32'(bus.rx_data), 32'(exp_data));
        end
    end

    task automatic drive_bit(input logic b);
        rs232_rx = b;
        repeat (bit_clks) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        rs232_rx = 1'b1;
        repeat (n * bit_clks) @(posedge clk);
        #1;
    endtask

    // Frame outcome comes from the line contents alone: stop bit first, then parity.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        exp_t e;
        e.data = d;
        if (!stop_b) e.kind = K_FERR;
`ifdef UART_RX_PARITY_EN
        else if ((^d ^ par_b) != 1'b0) e.kind = K_PERR;
`endif
        else e.kind = K_VALID;
        q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_b);
`endif
        drive_bit(stop_b);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3 * bit_clks && q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int v0;
        int f0;
        int p0;
        int h0;
        int hi;
        int lo_lim;
        int hi_lim;
        logic [7:0] d;
        logic       stop_ok;
        logic       par;

        rst_n    = 1'b0;
        rs232_rx = 1'b1;
        bit_clks = 80;
        repeat (5) @(posedge clk);
        #1;
        check("por_rx_data", 32'(bus.rx_data), 32'h00);
        check("por_bps_start", 32'(bps_start), 32'd0);
        rst_n = 1'b1;
        idle_bits(1);

        // Reset in the middle of data bit 3 of 0xA5.
        d = 8'hA5;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        rs232_rx = d[3];
        repeat (bit_clks / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_bps_start", 32'(bps_start), 32'd0);
        check("midrst_rx_int", 32'(bus.rx_int), 32'd0);
        check("midrst_rx_data", 32'(bus.rx_data), 32'h00);
        rs232_rx = 1'b1;
        repeat (2 * bit_clks) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_bits(2);
        send_frame(8'h3C, 1'b1, ^8'h3C);
        idle_bits(1);
        wait_drain();
        check("after_rst_rx_data", 32'(bus.rx_data), 32'h3C);

        // Nominal 0x55 at the real baud divisor.
        bit_clks = 1303;
        v0 = n_valid;
        h0 = bps_hi;
        send_frame(8'h55, 1'b1, ^8'h55);
        idle_bits(1);
        wait_drain();
        hi = bps_hi - h0;
        lo_lim = FRAME_BITS_AFTER_START * 1303 + 651 - 130;
        hi_lim = FRAME_BITS_AFTER_START * 1303 + 651 + 130;
        check("nominal_valid_count", 32'(n_valid - v0), 32'd1);
        check("nominal_rx_data", 32'(bus.rx_data), 32'h55);
        check("nominal_bps_width", 32'(hi >= lo_lim && hi <= hi_lim), 32'd1);

        // Glitch: 400-cycle low pulse is shorter than the mid-start sample point.
        v0 = n_valid + n_ferr + n_perr;
        rs232_rx = 1'b0;
        repeat (400) @(posedge clk);
        #1;
        rs232_rx = 1'b1;
        repeat (1303) @(posedge clk);
        #1;
        check("glitch_bps_start", 32'(bps_start), 32'd0);
        check("glitch_rx_data", 32'(bus.rx_data), 32'h55);
        check("glitch_no_strobe", 32'(n_valid + n_ferr + n_perr - v0), 32'd0);

        // Frame error then 20-bit break, then a clean frame.
        bit_clks = 80;
        f0 = n_ferr;
        send_frame(8'hF0, 1'b0, ^8'hF0);
        repeat (20 * bit_clks) @(posedge clk);
        #1;
        check("ferr_count", 32'(n_ferr - f0), 32'd1);
        check("ferr_rx_data_kept", 32'(bus.rx_data), 32'h55);
        check("break_bps_start", 32'(bps_start), 32'd0);
        idle_bits(1);
        send_frame(8'h12, 1'b1, ^8'h12);
        idle_bits(1);
        wait_drain();
        check("after_break_rx_data", 32'(bus.rx_data), 32'h12);

        // Back-to-back with no idle gap.
        v0 = n_valid;
        send_frame(8'h00, 1'b1, ^8'h00);
        send_frame(8'hFF, 1'b1, ^8'hFF);
        send_frame(8'h81, 1'b1, ^8'h81);
        idle_bits(1);
        wait_drain();
        check("b2b_valid_count", 32'(n_valid - v0), 32'd3);
        check("b2b_rx_data", 32'(bus.rx_data), 32'h81);

`ifdef UART_RX_PARITY_EN
        v0 = n_valid;
        p0 = n_perr;
        send_frame(8'h07, 1'b1, 1'b1);
        idle_bits(1);
        wait_drain();
        check("par_good_valid", 32'(n_valid - v0), 32'd1);
        check("par_good_rx_data", 32'(bus.rx_data), 32'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        idle_bits(1);
        wait_drain();
        check("par_bad_perr", 32'(n_perr - p0), 32'd1);
        check("par_bad_no_valid", 32'(n_valid - v0), 32'd1);
`else
        p0 = n_perr;
`endif

        // Random frames; a bad stop bit needs an idle bit before the next start edge.
        for (int n = 0; n < 30; n++) begin
            d       = 8'($urandom);
            stop_ok = ($urandom_range(0, 5) != 0);
            par     = ^d ^ ($urandom_range(0, 4) == 0);
            send_frame(d, stop_ok, par);
            idle_bits(int'($urandom_range(stop_ok ? 0 : 1, 2)));
        end
        idle_bits(1);
        wait_drain();
        check("final_bps_start", 32'(bps_start), 32'd0);
`ifndef UART_RX_PARITY_EN
        check("parity_err_tied_low", 32'(n_perr - p0), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
